// File: rtl/rf_pkg.sv
// Shared widths, FSM encoding and clear-sequence bounds for the register-file
// write arbiter.
package rf_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] CLEAR_FIRST = 5'd1;
    localparam logic [AW-1:0] CLEAR_LAST  = 5'd31;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Two writeback requesters (ALU = 0, load = 1) with valid/ready handshakes
// toward the register-file write arbiter.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a conflict the side
// that did not win last time wins. Grants are one-hot or all-zero.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    // Combinational grant decode from the current valids and last winner.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case ({valid1, valid0})
            2'b01: grant0 = 1'b1;
            2'b10: grant1 = 1'b1;
            2'b11: begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: optionally zeroes x1..x31 after reset, then
// merges the ALU and load writebacks onto the single registered write port.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   req,
    output logic [AW-1:0]       A3,
    output logic [DW-1:0]       WD3,
    output logic                WE3,
    output logic                init_done
);

    state_t        state_r,  state_nxt_s;
    logic [AW-1:0] cnt_r,    cnt_nxt_s;
    logic          last_grant_r, last_grant_nxt_s;
    logic [AW-1:0] a3_r,     a3_nxt_s;
    logic [DW-1:0] wd3_r,    wd3_nxt_s;
    logic          we3_r,    we3_nxt_s;
    logic          run_s;
    logic          grant0_s, grant1_s;
    logic          xfer0_s,  xfer1_s;

    assign run_s = (state_r == RUN);

    // Arbitration is only enabled in RUN, so CLEAR never hands out a ready.
    rr_arb2 u_rr_arb2 (
        .valid0     (req.req0_valid & run_s),
        .valid1     (req.req1_valid & run_s),
        .last_grant (last_grant_r),
        .grant0     (grant0_s),
        .grant1     (grant1_s)
    );

    assign req.req0_ready = grant0_s;
    assign req.req1_ready = grant1_s;
    assign xfer0_s        = req.req0_valid & grant0_s;
    assign xfer1_s        = req.req1_valid & grant1_s;

    // Next-state and next write-port values; A3/WD3 hold when nothing transfers.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        last_grant_nxt_s = last_grant_r;
        a3_nxt_s         = a3_r;
        wd3_nxt_s        = wd3_r;
        we3_nxt_s        = 1'b0;
        case (state_r)
            CLEAR: begin
                a3_nxt_s  = cnt_r;
                wd3_nxt_s = {DW{1'b0}};
                we3_nxt_s = 1'b1;
                cnt_nxt_s = cnt_r + 5'd1;
                if (cnt_r == CLEAR_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            RUN: begin
                // x0 writes are accepted but never enabled toward the file.
                if (xfer0_s) begin
                    a3_nxt_s         = req.req0_addr;
                    wd3_nxt_s        = req.req0_data;
                    we3_nxt_s        = (req.req0_addr != {AW{1'b0}});
                    last_grant_nxt_s = 1'b0;
                end else if (xfer1_s) begin
                    a3_nxt_s         = req.req1_addr;
                    wd3_nxt_s        = req.req1_data;
                    we3_nxt_s        = (req.req1_addr != {AW{1'b0}});
                    last_grant_nxt_s = 1'b1;
                end else begin
                    we3_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = CLEAR;
                cnt_nxt_s   = CLEAR_FIRST;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear counter, round-robin history and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= CLEAR_FIRST;
            last_grant_r <= 1'b1;
            a3_r         <= {AW{1'b0}};
            wd3_r        <= {DW{1'b0}};
            we3_r        <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            a3_r         <= a3_nxt_s;
            wd3_r        <= wd3_nxt_s;
            we3_r        <= we3_nxt_s;
        end
    end

    assign A3        = a3_r;
    assign WD3       = wd3_r;
    assign WE3       = we3_r;
    assign init_done = run_s;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero x1..x31 after reset, 0 = skip clearing.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: write request from the ALU writeback (0) or the load writeback (1).
REQ-005 SHALL have ports req0_addr/req1_addr, input, 5 each: destination register.
REQ-006 SHALL have ports req0_data/req1_data, input, 32 each: write data.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each: grant; a transfer occurs when valid and ready are both high on a rising edge.
REQ-008 SHALL have ports A3 (output, 5), WD3 (output, 32) and WE3 (output, 1), connected directly to the register-file write port.
REQ-009 SHALL have port init_done, output, 1: high once the register file is cleared and requests are being accepted.

Function
REQ-010 SHALL have two states: CLEAR (zero registers) and RUN (arbitrate requests).
REQ-011 SHALL, in CLEAR, hold a 5-bit counter from 1 to 31 and register one write per cycle with A3=counter, WD3=0, WE3=1.
REQ-012 SHALL drive req0_ready=req1_ready=0 and init_done=0 in CLEAR.
REQ-013 SHALL move to RUN on the same edge that loads A3=31, so init_done=1 in the cycle where the A3=31 write is presented.
REQ-014 SHALL make init_done equal to (state==RUN), decoded combinationally from the state register.
REQ-015 SHALL, in RUN, generate ready combinationally: a single valid requester gets ready=1; if both are valid, the one not granted last time gets ready=1; if neither is valid, both readys are 0.
REQ-016 SHALL never assert both readys in the same cycle.
REQ-017 SHALL hold a last_grant bit that updates only on a completed transfer.
REQ-018 SHALL register a transfer on its edge into A3/WD3/WE3, giving exactly 1 cycle latency from handshake to write presentation.
REQ-019 SHALL set WE3=1 for a transfer only if its addr≠0; a transfer with addr=0 is accepted, updates last_grant, and presents WE3=0.
REQ-020 SHALL drive WE3=0 in any RUN cycle that follows a cycle with no transfer; A3/WD3 are then don't-care but SHALL hold their previous values.
REQ-021 SHALL sustain one write per cycle with no bubbles under continuous requests.
REQ-022 SHALL have no internal queue: a requester that is not granted stalls with its valid held, and its addr/data SHALL stay stable while waiting.

Reset
REQ-023 SHALL, while rst=1 at an edge, set WE3=0, A3=0, WD3=0, last_grant=1 (so req0 wins the first conflict), counter=1, and state=CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-024 SHALL, with CLEAR_ON_RESET=1, present the first clear write (A3=1) in the cycle after the first edge with rst=0.
REQ-025 SHALL treat rst asserted mid-CLEAR or mid-RUN as a full restart: the clear sequence restarts from 1 and any not-yet-presented grant is lost.
REQ-026 SHALL NOT retract a write already presented when rst rises; the register file samples it on that edge.

Structure
REQ-027 SHALL place AW=5, DW=32, the state encoding (CLEAR, RUN) and CLEAR_LAST=31 in the shared package rf_pkg.
REQ-028 SHALL implement the 2-way round-robin grant logic (valids and last_grant in, one-hot ready out) as sub-module rr_arb2.
REQ-029 SHALL keep the output stage and FSM in rf_write_arbiter; RTL target is about 150 lines.

Verification
REQ-030 SHALL cover reset release with CLEAR_ON_RESET=1 and no requests -> WE3=1 for A3=1..31 on 31 consecutive cycles, WD3=0, then WE3=0, init_done=1 from the A3=31 cycle.
REQ-031 SHALL cover both requesters valid continuously after init_done (req0 addr 5 data 0x11, req1 addr 6 data 0x22) -> writes alternate 5,6,5,6, req0 first, one per cycle.
REQ-032 SHALL cover only req1 valid, addr 0, data 0xDEAD -> req1_ready=1, next cycle WE3=0; then both valid -> req0 granted.
REQ-033 SHALL cover rst for 1 cycle at clear counter 17 -> clear restarts at A3=1, with init_done low throughout.
REQ-034 SHALL cover CLEAR_ON_RESET=0 with req0 valid at reset release (addr 3, data 0x7) -> ready in the first cycle, A3=3/WD3=7/WE3=1 the next.
REQ-035 SHALL cover valid asserted during CLEAR -> ready stays 0 until init_done, with no lost or duplicated write.
